// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_pkg
// Brief    : Shared device addresses, FSM state and device-select encodings
//            for the LC-3 memory / memory-mapped I/O controller.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    DEV_NONE = 3'd0,
    DEV_KBSR = 3'd1,
    DEV_KBDR = 3'd2,
    DEV_DSR  = 3'd3,
    DEV_DDR  = 3'd4
  } dev_t;

endpackage
`default_nettype wire

// File: rtl/mem_io_addr_dec.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_addr_dec
// Brief    : Combinational decode of the MAR address to a device select;
//            anything that is not a device register maps to memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_addr_dec
  import lc3_pkg::*;
(
  input  logic [15:0] addr,
  output dev_t        dev
);

  always_comb begin
    dev = DEV_NONE;
    case (addr)
      KBSR_ADDR: dev = DEV_KBSR;
      KBDR_ADDR: dev = DEV_KBDR;
      DSR_ADDR:  dev = DEV_DSR;
      DDR_ADDR:  dev = DEV_DDR;
      default:   dev = DEV_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_ctrl
// Brief    : LC-3 memory / memory-mapped I/O access controller with the
//            keyboard and display device registers. Optional keyboard
//            interrupt enabled by defining MEM_IO_KB_INT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_ctrl
  import lc3_pkg::*;
#(
  parameter int MEM_LATENCY = 2
)
(
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Mio_En,
  input  logic        i_R_W,
  input  logic [15:0] i_Mar,
  input  logic [15:0] i_Mdr,
  output logic        o_R,
  output logic        o_Ld_Mdr,
  output logic        o_Miomux_Sel,
  output logic [15:0] o_Io_Data,
  output logic        o_Mem_En,
  output logic        o_Mem_We,
  input  logic        i_Kb_Valid,
  input  logic [7:0]  i_Kb_Data,
  output logic        o_Kb_Ack,
  output logic        o_Disp_Valid,
  output logic [7:0]  o_Disp_Data,
  input  logic        i_Disp_Ready
`ifdef MEM_IO_KB_INT_EN
  ,
  output logic        o_Kb_Int
`endif
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t           state;
  state_t           state_nxt;
  dev_t             dev_dec;
  dev_t             dev_q;
  logic             rw_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             kb_full;
  logic             kb_ie;
  logic [7:0]       kbdr;
  logic             dsr_rdy;
  logic [15:0]      ddr;
  logic             disp_valid;
  logic             kb_ack;

  logic             done;
  logic             kbdr_rd;
  logic             ddr_wr;
  logic             kbsr_wr;
  logic             kb_take;
  logic             disp_hs;
  logic             unused_bits;

  mem_io_addr_dec u_addr_dec (
    .addr (i_Mar),
    .dev  (dev_dec)
  );

  assign done    = (state == ST_DONE);
  assign kbdr_rd = done && !rw_q && (dev_q == DEV_KBDR);
  assign ddr_wr  = done &&  rw_q && (dev_q == DEV_DDR);
  assign kbsr_wr = done &&  rw_q && (dev_q == DEV_KBSR);
  // A KBDR read clearing the full flag takes priority over a new character.
  assign kb_take = i_Kb_Valid && !kb_full && !kbdr_rd;
  assign disp_hs = disp_valid && i_Disp_Ready;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rw_q     <= 1'b0;
      dev_q    <= DEV_NONE;
      wait_cnt <= '0;
    end else if (state == ST_IDLE && i_Mio_En) begin
      rw_q     <= i_R_W;
      dev_q    <= dev_dec;
      wait_cnt <= CNT_W'(MEM_LATENCY - 1);
    end else if (state == ST_MEM && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    o_R          = 1'b0;
    o_Ld_Mdr     = 1'b0;
    o_Miomux_Sel = 1'b0;
    o_Io_Data    = 16'h0000;
    o_Mem_En     = 1'b0;
    o_Mem_We     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Mio_En) begin
          state_nxt = (dev_dec == DEV_NONE) ? ST_MEM : ST_DONE;
        end
      end
      ST_MEM: begin
        o_Mem_En = 1'b1;
        o_Mem_We = rw_q;
        if (wait_cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_R       = 1'b1;
        o_Ld_Mdr  = !rw_q;
        state_nxt = ST_HOLD;
        if (!rw_q && dev_q != DEV_NONE) begin
          o_Miomux_Sel = 1'b1;
          case (dev_q)
            DEV_KBSR: o_Io_Data = {kb_full, kb_ie, 14'b0};
            DEV_KBDR: o_Io_Data = {8'h00, kbdr};
            DEV_DSR:  o_Io_Data = {dsr_rdy, 15'b0};
            default:  o_Io_Data = 16'h0000;
          endcase
        end
      end
      ST_HOLD: begin
        if (!i_Mio_En) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      kb_full    <= 1'b0;
      kbdr       <= 8'h00;
      kb_ack     <= 1'b0;
      dsr_rdy    <= 1'b1;
      ddr        <= 16'h0000;
      disp_valid <= 1'b0;
    end else begin
      kb_ack <= kb_take;
      if (kb_take) begin
        kb_full <= 1'b1;
        kbdr    <= i_Kb_Data;
      end else if (kbdr_rd) begin
        kb_full <= 1'b0;
      end
      // DDR writes while the display is busy are dropped.
      if (ddr_wr && dsr_rdy) begin
        ddr        <= i_Mdr;
        dsr_rdy    <= 1'b0;
        disp_valid <= 1'b1;
      end else if (disp_hs) begin
        disp_valid <= 1'b0;
        dsr_rdy    <= 1'b1;
      end
    end
  end

`ifdef MEM_IO_KB_INT_EN
  logic kb_int_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      kb_ie    <= 1'b0;
      kb_int_q <= 1'b0;
    end else begin
      if (kbsr_wr) begin
        kb_ie <= i_Mdr[14];
      end
      kb_int_q <= kb_full & kb_ie;
    end
  end

  assign o_Kb_Int    = kb_int_q;
  assign unused_bits = ^ddr[15:8];
`else
  assign kb_ie       = 1'b0;
  assign unused_bits = ^{ddr[15:8], kbsr_wr};
`endif

  assign o_Kb_Ack     = kb_ack;
  assign o_Disp_Valid = disp_valid;
  assign o_Disp_Data  = ddr[7:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_ctrl
// Brief    : Self-checking bench for mem_io_ctrl: transaction-level reference
//            model, per-cycle output compare, directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mio_en = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr = 16'h0000;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        disp_ready = 1'b0;
  logic        o_R, o_Ld_Mdr, o_Miomux_Sel, o_Mem_En, o_Mem_We, o_Kb_Ack, o_Disp_Valid;
  logic [15:0] o_Io_Data;
  logic [7:0]  o_Disp_Data;
`ifdef MEM_IO_KB_INT_EN
  logic        o_Kb_Int;
`endif

  always #5 clk = ~clk;

  mem_io_ctrl #(.MEM_LATENCY(LAT)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Mio_En     (mio_en),
    .i_R_W        (r_w),
    .i_Mar        (mar),
    .i_Mdr        (mdr),
    .o_R          (o_R),
    .o_Ld_Mdr     (o_Ld_Mdr),
    .o_Miomux_Sel (o_Miomux_Sel),
    .o_Io_Data    (o_Io_Data),
    .o_Mem_En     (o_Mem_En),
    .o_Mem_We     (o_Mem_We),
    .i_Kb_Valid   (kb_valid),
    .i_Kb_Data    (kb_data),
    .o_Kb_Ack     (o_Kb_Ack),
    .o_Disp_Valid (o_Disp_Valid),
    .o_Disp_Data  (o_Disp_Data),
    .i_Disp_Ready (disp_ready)
`ifdef MEM_IO_KB_INT_EN
    ,
    .o_Kb_Int     (o_Kb_Int)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 = memory, 1 = KBSR, 2 = KBDR, 3 = DSR, 4 = DDR
  function automatic int dev_of(input logic [15:0] a);
    case (a)
      16'hFE00: return 1;
      16'hFE02: return 2;
      16'hFE04: return 3;
      16'hFE06: return 4;
      default:  return 0;
    endcase
  endfunction

  bit          model_ok = 0;
  int          phase;            // 0 idle, 1 access in flight, 2 waiting for release
  int          acc_t, acc_d, acc_dev;
  bit          acc_rw;
  logic [15:0] acc_data;
  bit          m_full, m_ie, m_dsr_rdy, m_pend;
  logic [7:0]  m_kbdr, m_ddr;
  logic        e_r, e_ld, e_sel, e_men, e_mwe, e_ack, e_int;
  logic [15:0] e_io;

  // cyc names the clock period that follows the edge just taken
  initial forever begin : model
    bit commit, clr, cap, hs;
    @(posedge clk);
    cyc++;
    if (rst) begin
      phase = 0; m_full = 0; m_ie = 0; m_dsr_rdy = 1; m_pend = 0;
      m_kbdr = 8'h00; m_ddr = 8'h00;
      e_r = 0; e_ld = 0; e_sel = 0; e_men = 0; e_mwe = 0; e_ack = 0; e_int = 0;
      e_io = 16'h0000;
      model_ok = 1;
    end else if (model_ok) begin
      commit = (phase == 1) && (cyc == acc_d + 1);
      clr    = commit && (acc_dev == 2) && !acc_rw;
      cap    = kb_valid && !m_full && !clr;
      hs     = m_pend && disp_ready;
      e_int  = m_full && m_ie;
      if (commit && acc_rw && acc_dev == 4 && m_dsr_rdy) begin
        m_ddr = acc_data[7:0]; m_dsr_rdy = 0; m_pend = 1;
      end
`ifdef MEM_IO_KB_INT_EN
      if (commit && acc_rw && acc_dev == 1) m_ie = acc_data[14];
`endif
      if (clr) m_full = 0;
      if (hs) begin m_pend = 0; m_dsr_rdy = 1; end
      if (cap) begin m_full = 1; m_kbdr = kb_data; end
      e_ack = cap;
      if (commit) phase = 2;
      else if (phase == 2 && !mio_en) phase = 0;
      else if (phase == 0 && mio_en) begin
        acc_t = cyc; acc_dev = dev_of(mar); acc_rw = r_w; acc_data = mdr;
        acc_d = cyc + ((acc_dev == 0) ? LAT : 0);
        phase = 1;
      end
      e_men = (phase == 1) && (acc_dev == 0) && (cyc >= acc_t) && (cyc < acc_d);
      e_mwe = e_men && acc_rw;
      e_r   = (phase == 1) && (cyc == acc_d);
      e_ld  = e_r && !acc_rw;
      e_sel = e_ld && (acc_dev != 0);
      e_io  = 16'h0000;
      if (e_sel) begin
        case (acc_dev)
          1: e_io = {m_full, m_ie, 14'b0};
          2: e_io = {8'h00, m_kbdr};
          3: e_io = {m_dsr_rdy, 15'b0};
          default: e_io = 16'h0000;
        endcase
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (model_ok) begin
      chk("o_R", o_R, e_r);
      chk("o_Ld_Mdr", o_Ld_Mdr, e_ld);
      chk("o_Miomux_Sel", o_Miomux_Sel, e_sel);
      chk("o_Io_Data", o_Io_Data, e_io);
      chk("o_Mem_En", o_Mem_En, e_men);
      chk("o_Mem_We", o_Mem_We, e_mwe);
      chk("o_Kb_Ack", o_Kb_Ack, e_ack);
      chk("o_Disp_Valid", o_Disp_Valid, m_pend);
      chk("o_Disp_Data", o_Disp_Data, m_ddr);
`ifdef MEM_IO_KB_INT_EN
      chk("o_Kb_Int", o_Kb_Int, e_int);
`endif
    end
  end

  bit kb_auto = 0;
  bit disp_auto = 0;

  initial forever begin : kb_agent
    @(negedge clk);
    if (kb_auto) begin
      if (kb_valid && o_Kb_Ack) kb_valid = 0;
      else if (!kb_valid && $urandom_range(0, 5) == 0) begin
        kb_valid = 1;
        kb_data  = 8'($urandom);
      end
    end
  end

  initial forever begin : disp_agent
    @(negedge clk);
    if (disp_auto) disp_ready = ($urandom_range(0, 2) == 0);
  end

  // Returns with i_Mio_En low for one edge after o_R so the next access can start.
  task automatic access(input logic [15:0] a, input bit w, input logic [15:0] d,
                        input int hold, output logic [15:0] rd, output int lat,
                        output logic [2:0] flags);
    int n;
    bit got;
    @(negedge clk);
    mio_en = 1; r_w = w; mar = a; mdr = d;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (o_R) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: got no o_R expected o_R within 20 cycles (addr %h)", a);
    end
    rd = o_Io_Data; lat = n; flags = {o_Ld_Mdr, o_Miomux_Sel, o_Mem_En};
    repeat (hold) @(negedge clk);
    mio_en = 0;
    @(negedge clk);
  endtask

  logic [15:0] rd;
  int          lat;
  logic [2:0]  fl;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_o_R", o_R, 1'b0);
    chk("rst_io_data", o_Io_Data, 16'h0000);
    chk("rst_disp_valid", o_Disp_Valid, 1'b0);
    rst = 0;

    access(16'h3000, 0, 16'h0000, 0, rd, lat, fl);
    chk("mem_rd_latency", 16'(lat), 16'd3);
    chk("mem_rd_flags", 16'(fl), 16'b100);

    access(16'h3001, 1, 16'hBEEF, 0, rd, lat, fl);
    chk("mem_wr_latency", 16'(lat), 16'd3);
    chk("mem_wr_flags", 16'(fl), 16'b000);

    access(16'hFE04, 0, 16'h0000, 0, rd, lat, fl);
    chk("dsr_reset", rd, 16'h8000);
    chk("dev_latency", 16'(lat), 16'd1);

    @(negedge clk); kb_valid = 1; kb_data = 8'h41;
    @(negedge clk); chk("kb_ack_pulse", o_Kb_Ack, 1'b1); kb_valid = 0;
    access(16'hFE00, 0, 16'h0000, 0, rd, lat, fl);
    chk("kbsr_full", rd, 16'h8000);
    chk("kbsr_flags", 16'(fl), 16'b110);
    access(16'hFE02, 0, 16'h0000, 0, rd, lat, fl);
    chk("kbdr_41", rd, 16'h0041);
    access(16'hFE00, 0, 16'h0000, 0, rd, lat, fl);
    chk("kbsr_empty", rd, 16'h0000);

    disp_ready = 0;
    access(16'hFE06, 1, 16'h0058, 0, rd, lat, fl);
    chk("disp_valid_set", o_Disp_Valid, 1'b1);
    chk("disp_data_58", o_Disp_Data, 8'h58);
    access(16'hFE04, 0, 16'h0000, 0, rd, lat, fl);
    chk("dsr_busy", rd, 16'h0000);
    access(16'hFE06, 1, 16'h0077, 0, rd, lat, fl);
    chk("ddr_write_dropped", o_Disp_Data, 8'h58);
    access(16'hFE06, 0, 16'h0000, 0, rd, lat, fl);
    chk("ddr_read_zero", rd, 16'h0000);
    disp_ready = 1;
    @(negedge clk); chk("disp_valid_clr", o_Disp_Valid, 1'b0); disp_ready = 0;
    access(16'hFE04, 0, 16'h0000, 0, rd, lat, fl);
    chk("dsr_ready_again", rd, 16'h8000);

    @(negedge clk); kb_valid = 1; kb_data = 8'h41;
    @(negedge clk); kb_data = 8'h42;
    @(negedge clk); chk("kb_retry_no_ack", o_Kb_Ack, 1'b0);
    access(16'hFE02, 0, 16'h0000, 0, rd, lat, fl);
    chk("race_kbdr_old", rd, 16'h0041);
    chk("race_no_ack", o_Kb_Ack, 1'b0);
    @(negedge clk); chk("race_ack_late", o_Kb_Ack, 1'b1); kb_valid = 0;
    access(16'hFE02, 0, 16'h0000, 0, rd, lat, fl);
    chk("kbdr_42", rd, 16'h0042);

    access(16'hFE02, 1, 16'h1234, 0, rd, lat, fl);
    access(16'hFE04, 1, 16'h0000, 0, rd, lat, fl);
    access(16'hFE00, 1, 16'hFFFF, 0, rd, lat, fl);
    access(16'hFE00, 0, 16'h0000, 0, rd, lat, fl);
`ifdef MEM_IO_KB_INT_EN
    chk("kbsr_ie_only", rd, 16'h4000);
`else
    chk("kbsr_ie_only", rd, 16'h0000);
`endif
    access(16'hFE04, 0, 16'h0000, 4, rd, lat, fl);
    chk("dsr_after_ignored", rd, 16'h8000);

    access(16'hFE06, 1, 16'h0033, 0, rd, lat, fl);
    @(negedge clk); mio_en = 1; r_w = 0; mar = 16'h3000;
    @(negedge clk); chk("pre_rst_mem_en", o_Mem_En, 1'b1);
    rst = 1; mio_en = 0;
    @(negedge clk);
    chk("rst_mid_no_r", o_R, 1'b0);
    chk("rst_mid_mem_en", o_Mem_En, 1'b0);
    chk("rst_mid_disp_valid", o_Disp_Valid, 1'b0);
    chk("rst_mid_disp_data", o_Disp_Data, 8'h00);
    rst = 0;
    access(16'hFE04, 0, 16'h0000, 0, rd, lat, fl);
    chk("rst_mid_dsr", rd, 16'h8000);

`ifdef MEM_IO_KB_INT_EN
    access(16'hFE00, 1, 16'h4000, 0, rd, lat, fl);
    @(negedge clk); kb_valid = 1; kb_data = 8'h55;
    @(negedge clk); kb_valid = 0;
    @(negedge clk); chk("kb_int_set", o_Kb_Int, 1'b1);
    access(16'hFE02, 0, 16'h0000, 0, rd, lat, fl);
    @(negedge clk); chk("kb_int_clr", o_Kb_Int, 1'b0);
`endif

    kb_auto = 1; disp_auto = 1;
    for (int i = 0; i < 250; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 7))
        0: a = 16'hFE00;
        1: a = 16'hFE02;
        2: a = 16'hFE04;
        3: a = 16'hFE06;
        4: a = 16'hFE01;
        5: a = 16'hFE08;
        default: a = 16'($urandom);
      endcase
      access(a, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2), rd, lat, fl);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    kb_auto = 0; disp_auto = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory and memory-mapped I/O access controller for the LC-3 datapath. It sits between the MAR/MDR registers and main memory plus the keyboard/display devices. It decodes the MAR address, runs a wait-stated memory access or a single-cycle device access, and drives the MIO mux select, LD_MDR and the R (ready) handshake back to the control FSM. It owns the KBSR/KBDR/DSR/DDR device registers and their ready/valid handshakes to the external keyboard and display.

## Interface
- MEM_LATENCY, 2: memory wait cycles per access; legal range is 1 or more.
- i_Clk  in  1  clock; all logic on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Mio_En  in  1  access request from the control FSM; held high until o_R.
- i_R_W  in  1  1 = write, 0 = read; sampled with i_Mio_En in IDLE.
- i_Mar  in  16  access address.
- i_Mdr  in  16  write data.
- o_R  out  1  one-cycle access-complete pulse.
- o_Ld_Mdr  out  1  one-cycle pulse with o_R on reads only.
- o_Miomux_Sel  out  1  0 = memory data, 1 = o_Io_Data.
- o_Io_Data  out  16  device read data, valid while o_Miomux_Sel = 1.
- o_Mem_En, o_Mem_We  out  1 each  memory strobe and write enable.
- i_Kb_Valid  in  1  keyboard has a character.
- i_Kb_Data  in  8  keyboard character.
- o_Kb_Ack  out  1  one-cycle pulse when the character is captured.
- o_Disp_Valid  out  1  display character pending.
- o_Disp_Data  out  8  DDR[7:0].
- i_Disp_Ready  in  1  display accepts the character.
- o_Kb_Int  out  1  keyboard interrupt; exists only with the macro defined (see Configuration).

## Operation
- Address decode:
  - xFE00 = KBSR, xFE02 = KBDR, xFE04 = DSR, xFE06 = DDR.
  - Every other address goes to memory.
- FSM states: IDLE, MEM, DONE, HOLD.
  - IDLE: when i_Mio_En = 1, latch i_R_W and the decode result. A memory access goes to MEM; a device access goes to DONE.
  - MEM: o_Mem_En = 1 and o_Mem_We = latched R_W for MEM_LATENCY cycles, then go to DONE.
  - DONE: o_R = 1; o_Ld_Mdr = 1 if the access is a read; o_Miomux_Sel = 1 for a device read. Device side effects commit in this cycle. Next state is HOLD.
  - HOLD: wait for i_Mio_En = 0, then go to IDLE. An i_Mio_En held high never starts a second access.
- Keyboard:
  - If i_Kb_Valid = 1 and KBSR[15] = 0: KBDR <= {8'h00, i_Kb_Data}, KBSR[15] <= 1, and o_Kb_Ack pulses.
  - If KBSR[15] = 1, the character is not acked; the keyboard keeps i_Kb_Valid high and retries.
  - A KBDR read (in DONE) clears KBSR[15]. If the clear coincides with i_Kb_Valid, the clear wins and there is no ack.
- Display:
  - A DDR write while DSR[15] = 1: DDR <= i_Mdr, DSR[15] <= 0, o_Disp_Valid <= 1.
  - o_Disp_Valid stays high until i_Disp_Ready; on valid && ready, o_Disp_Valid <= 0 and DSR[15] <= 1 on the next edge.
  - A DDR write while DSR[15] = 0 is dropped, but the access still completes with o_R.
- Ignored writes:
  - Writes to KBDR and DSR are ignored.
  - Writes to KBSR bits other than 14 are ignored.
- Reads:
  - DDR reads return 0.
  - KBSR reads return {KBSR[15], KBSR[14], 14'b0}.
  - DSR reads return {DSR[15], 15'b0}.
- Reset values:
  - FSM in IDLE; all strobes and pulses 0; o_Disp_Valid = 0.
  - KBSR = 0, KBDR = 0, DDR = 0, DSR = 16'h8000.
  - o_Io_Data = 0, o_Disp_Data = 0.
- Reset mid-access: return to IDLE immediately with no o_R, and any pending display character is discarded.

## Timing
- If i_Mio_En is sampled high in IDLE at edge t:
  - Memory access: MEM occupies t+1 .. t+MEM_LATENCY; o_R is high in cycle t+MEM_LATENCY+1.
  - Device access: o_R is high in cycle t+1.
- Back-to-back accesses need at least one cycle of i_Mio_En = 0 after o_R.
- o_Kb_Ack is high in the cycle after i_Kb_Valid is sampled with KBSR[15] = 0.
- KBSR[15] is visible to a read that starts on the next edge.
- The DSR[15] set after a display handshake is visible one cycle after the valid && ready edge.

## Configuration
- MEM_IO_KB_INT_EN defined:
  - KBSR[14] is the interrupt enable, writable via a KBSR write (i_Mdr[14]); reset value 0.
  - o_Kb_Int = KBSR[15] & KBSR[14], registered.
- Undefined:
  - The o_Kb_Int port is absent.
  - KBSR[14] always reads 0, and writes to it are ignored.

## Structure
- Shared package lc3_pkg holds:
  - Constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR.
  - The FSM state enum.
  - A device-select enum (DEV_NONE, DEV_KBSR, DEV_KBDR, DEV_DSR, DEV_DDR).
- One sub-module: mem_io_addr_dec, a combinational decoder from i_Mar to the device-select value.
- The FSM, wait counter and device registers live in the top level.

## Test plan
- Memory read at x3000, MEM_LATENCY = 2, i_Mio_En high at edge 0 → o_Mem_En high in cycles 1–2; o_R and o_Ld_Mdr high in cycle 3; o_Miomux_Sel = 0.
- Keyboard sequence:
  - i_Kb_Valid with data x41 → o_Kb_Ack pulses; a KBSR read then returns x8000 with o_R in cycle t+1; a KBDR read returns x0041.
  - A further KBSR read returns x0000.
- Display handshake: with i_Disp_Ready = 0, write x0058 to xFE06 → o_Disp_Valid = 1, o_Disp_Data = x58, DSR reads x0000. A second DDR write is dropped. After i_Disp_Ready pulses, DSR reads x8000.
- Race: i_Kb_Valid high in the same cycle as a KBDR read's DONE → no ack and KBSR[15] = 0; the ack follows one cycle later.
- i_Rst asserted during MEM → no o_R; all outputs and registers return to their reset values; DSR = x8000.
- With MEM_IO_KB_INT_EN defined: write x4000 to KBSR, then a keyboard char → o_Kb_Int = 1; a KBDR read → o_Kb_Int = 0.
